// File: rtl/ps2_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_cmd_pkg
//  Description : Shared constants, parser state encoding and key-mapping
//                helpers for the PS/2-to-Tetris command controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_cmd_pkg;

  // Game command encoding (0 and 7 are never emitted)
  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_DOWN   = 3'd3;
  localparam logic [2:0] CMD_ROTATE = 3'd4;
  localparam logic [2:0] CMD_DROP   = 3'd5;
  localparam logic [2:0] CMD_PAUSE  = 3'd6;

  // Scancode prefixes and mapped key codes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;  // extended
  localparam logic [7:0] SC_RIGHT  = 8'h74;  // extended
  localparam logic [7:0] SC_DOWN   = 8'h72;  // extended
  localparam logic [7:0] SC_ROTATE = 8'h75;  // extended
  localparam logic [7:0] SC_DROP   = 8'h29;  // base (space)
  localparam logic [7:0] SC_PAUSE  = 8'h4D;  // base (P)

  // Prefix parser states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  // Translate a (prefix, code) pair into a game command; CMD_NONE if unmapped
  function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
    logic [2:0] c;
    c = CMD_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:   c = CMD_LEFT;
        SC_RIGHT:  c = CMD_RIGHT;
        SC_DOWN:   c = CMD_DOWN;
        SC_ROTATE: c = CMD_ROTATE;
        default:   c = CMD_NONE;
      endcase
    end else begin
      case (code)
        SC_DROP:   c = CMD_DROP;
        SC_PAUSE:  c = CMD_PAUSE;
        default:   c = CMD_NONE;
      endcase
    end
    return c;
  endfunction

  // One held-bit per mapped command; CMD_NONE maps to no bit
  function automatic logic [5:0] cmd_onehot(input logic [2:0] c);
    logic [5:0] oh;
    oh = '0;
    case (c)
      CMD_LEFT:   oh = 6'b000001;
      CMD_RIGHT:  oh = 6'b000010;
      CMD_DOWN:   oh = 6'b000100;
      CMD_ROTATE: oh = 6'b001000;
      CMD_DROP:   oh = 6'b010000;
      CMD_PAUSE:  oh = 6'b100000;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

  // Only movement commands are auto-repeated
  function automatic logic is_movement(input logic [2:0] c);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_DOWN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : Small synchronous FIFO with a registered head output.
//                A push while full is accepted only if a pop happens in the
//                same cycle; a pop while empty has no effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_next_rd;
  logic [AW:0]      w_next_count;
  logic [WIDTH-1:0] w_next_head;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign head  = r_head;

  // Accept/commit decisions and the value the head register takes next
  always_comb begin
    w_pop_ok  = pop & ~empty;
    w_push_ok = push & (~full | w_pop_ok);
    w_next_rd = w_pop_ok ? (r_rd + AW'(1)) : r_rd;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_next_count = r_count + (AW+1)'(1);
      2'b01:   w_next_count = r_count - (AW+1)'(1);
      default: w_next_count = r_count;
    endcase
    // The new head may be the entry being written this very cycle
    if (w_next_count == '0)
      w_next_head = '0;
    else if (w_push_ok && (w_next_rd == r_wr))
      w_next_head = push_data;
    else
      w_next_head = r_mem[w_next_rd];
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      r_rd    <= w_next_rd;
      r_count <= w_next_count;
      r_head  <= w_next_head;
    end
  end

  // Storage write; contents are only observed through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_cmd_ctrl
//  Description : PS/2 scancode stream to Tetris command queue. Parses
//                E0/F0 prefixes, filters typematic repeats, auto-repeats
//                held movement keys and queues commands for the game FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_cmd_ctrl
  import ps2_cmd_pkg::*;
#(
  parameter int REPEAT_DELAY = 5_000_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [7:0] drop_count
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  // Timer counts down to zero, so load one less than the interval
  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

  parse_state_t r_state;
  logic [5:0]   r_held;
  logic         r_rep_active;
  logic [2:0]   r_rep_cmd;
  logic [TW-1:0] r_timer;
  logic [7:0]   r_drop_count;

  logic       w_is_make;
  logic       w_is_break;
  logic       w_is_ext;
  logic [2:0] w_key_cmd;
  logic [5:0] w_key_oh;
  logic       w_parser_push;
  logic       w_clear_slot;
  logic       w_tick;
  logic       w_push;
  logic [2:0] w_push_data;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_overflow;

  // Classify the incoming byte as a make/break event given the prefix state
  always_comb begin
    w_is_make  = 1'b0;
    w_is_break = 1'b0;
    w_is_ext   = 1'b0;
    if (ps2_key_pressed) begin
      case (r_state)
        ST_IDLE:    w_is_make = (ps2_key_data != SC_EXT) && (ps2_key_data != SC_BRK);
        ST_EXT: begin
          w_is_make = (ps2_key_data != SC_BRK);
          w_is_ext  = 1'b1;
        end
        ST_BRK:     w_is_break = (ps2_key_data != SC_BRK);
        ST_EXT_BRK: begin
          w_is_break = 1'b1;
          w_is_ext   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_key_cmd     = map_key(w_is_ext, ps2_key_data);
  assign w_key_oh      = cmd_onehot(w_key_cmd);
  assign w_parser_push = w_is_make && (w_key_cmd != CMD_NONE) && ((r_held & w_key_oh) == '0);

  // Repeat slot is released only by the break of the key it tracks
  assign w_clear_slot = w_is_break && r_rep_active && (w_key_cmd == r_rep_cmd);
  assign w_tick       = r_rep_active && (r_timer == '0) && !w_clear_slot;

  // Parser pushes take priority; a colliding repeat tick is simply lost
  assign w_push      = w_parser_push | w_tick;
  assign w_push_data = w_parser_push ? w_key_cmd : r_rep_cmd;
  assign w_overflow  = w_push & w_fifo_full & ~cmd_ready;

  // Prefix parser: advances only on a byte strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ps2_key_pressed) begin
      case (r_state)
        ST_IDLE: begin
          if (ps2_key_data == SC_EXT)      r_state <= ST_EXT;
          else if (ps2_key_data == SC_BRK) r_state <= ST_BRK;
        end
        ST_EXT:     r_state <= (ps2_key_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     if (ps2_key_data != SC_BRK) r_state <= ST_IDLE;
        ST_EXT_BRK: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Held bits: make sets, break clears (used to reject typematic duplicates)
  always_ff @(posedge clk) begin
    if (!rst_n)          r_held <= '0;
    else if (w_is_make)  r_held <= r_held | w_key_oh;
    else if (w_is_break) r_held <= r_held & ~w_key_oh;
  end

  // Auto-repeat tracker for the most recently accepted movement make
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rep_active <= 1'b0;
      r_rep_cmd    <= CMD_NONE;
      r_timer      <= '0;
    end else if (w_parser_push && is_movement(w_key_cmd)) begin
      r_rep_active <= 1'b1;
      r_rep_cmd    <= w_key_cmd;
      r_timer      <= DELAY_LOAD;
    end else if (w_clear_slot) begin
      r_rep_active <= 1'b0;
    end else if (r_rep_active) begin
      r_timer <= (r_timer == '0) ? RATE_LOAD : (r_timer - TW'(1));
    end
  end

  // Saturating count of commands lost to a full queue
  always_ff @(posedge clk) begin
    if (!rst_n)                               r_drop_count <= '0;
    else if (w_overflow && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
  end

  cmd_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (cmd_ready),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head      (cmd)
  );

  assign cmd_valid  = ~w_fifo_empty;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_cmd_ctrl
//  Description : Directed self-checking bench for ps2_cmd_ctrl
//                (REPEAT_DELAY=20, REPEAT_RATE=10, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_cmd_ctrl;
  import ps2_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int s, p, q;

  typedef struct {
    int         t;
    logic [2:0] c;
  } beat_t;
  beat_t beats[$];

  ps2_cmd_ctrl #(
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (10),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .cmd_ready       (cmd_ready),
    .cmd_valid       (cmd_valid),
    .cmd             (cmd),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted handshake beat, stamped with the edge that pushed it
  always begin
    @(negedge clk);
    #1;
    if (rst_n && cmd_valid && cmd_ready) beats.push_back('{cyc, cmd});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int beat_time(input int idx);
    return (idx < beats.size()) ? beats[idx].t : -1;
  endfunction

  function automatic int beat_cmd(input int idx);
    return (idx < beats.size()) ? int'(beats[idx].c) : -1;
  endfunction

  // Present one byte strobe for exactly one rising edge; starts and ends on a negedge
  task automatic send(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = b;
    @(negedge clk);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("reset_valid", cmd_valid, 0);
    check("reset_cmd", cmd, 0);
    check("reset_drop", drop_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- single rotate ----------------
    cmd_ready = 1'b1;
    beats.delete();
    s = cyc;
    send(8'hE0); send(8'h75);
    check("rot_valid", cmd_valid, 1);
    check("rot_cmd", cmd, CMD_ROTATE);
    @(negedge clk);
    check("rot_drained", cmd_valid, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    repeat (3) @(negedge clk);
    check("rot_beats", beats.size(), 1);
    check("rot_beat_t", beat_time(0), s + 2);
    check("rot_beat_c", beat_cmd(0), CMD_ROTATE);

    // ---------------- typematic filter + auto-repeat ----------------
    beats.delete();
    s = cyc;
    send(8'hE0); send(8'h6B);
    p = s + 2;
    wait_until(p + 6);  send(8'hE0); send(8'h6B);
    wait_until(p + 13); send(8'hE0); send(8'h6B);
    wait_until(p + 20); send(8'hE0); send(8'h6B);
    wait_until(p + 42); send(8'hE0); send(8'hF0); send(8'h6B);
    wait_until(p + 60);
    check("rep_beats", beats.size(), 4);
    check("rep_t0", beat_time(0), p);
    check("rep_t1", beat_time(1), p + 20);
    check("rep_t2", beat_time(2), p + 30);
    check("rep_t3", beat_time(3), p + 40);
    check("rep_c0", beat_cmd(0), CMD_LEFT);
    check("rep_c3", beat_cmd(3), CMD_LEFT);

    // ---------------- prefix handling ----------------
    beats.delete();
    send(8'hF0); send(8'h29);
    send(8'hE0); send(8'h29);
    s = cyc;
    send(8'h29);
    repeat (3) @(negedge clk);
    check("pfx_beats", beats.size(), 1);
    check("pfx_t", beat_time(0), s + 1);
    check("pfx_c", beat_cmd(0), CMD_DROP);
    send(8'hF0); send(8'h29);

    // ---------------- overflow ----------------
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    beats.delete();
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'h75);
    send(8'h29);
    send(8'h4D);
    check("ovf_valid", cmd_valid, 1);
    check("ovf_head", cmd, CMD_LEFT);
    check("ovf_drops", drop_count, 2);
    send(8'hF0); send(8'h4D);
    check("ovf_head_stable", cmd, CMD_LEFT);
    cmd_ready = 1'b1;
    send(8'h4D);
    check("ovf_pushpop_drops", drop_count, 2);
    repeat (6) @(negedge clk);
    check("ovf_drained", cmd_valid, 0);
    check("ovf_beats", beats.size(), 5);
    check("ovf_c0", beat_cmd(0), CMD_LEFT);
    check("ovf_c1", beat_cmd(1), CMD_RIGHT);
    check("ovf_c2", beat_cmd(2), CMD_DOWN);
    check("ovf_c3", beat_cmd(3), CMD_ROTATE);
    check("ovf_c4", beat_cmd(4), CMD_PAUSE);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h29);
    send(8'hF0); send(8'h4D);
    repeat (20) @(negedge clk);
    check("ovf_no_leak", beats.size(), 5);

    // ---------------- repeat tick collides with DOWN make ----------------
    beats.delete();
    s = cyc;
    send(8'hE0); send(8'h6B);
    p = s + 2;
    wait_until(p + 18); send(8'hE0); send(8'h72);
    wait_until(p + 25);
    check("col_beats", beats.size(), 2);
    check("col_t0", beat_time(0), p);
    check("col_c0", beat_cmd(0), CMD_LEFT);
    check("col_t1", beat_time(1), p + 20);
    check("col_c1", beat_cmd(1), CMD_DOWN);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h6B);

    // ---------------- collision with ROTATE: timer still reloads rate ----------------
    repeat (2) @(negedge clk);
    beats.delete();
    s = cyc;
    send(8'hE0); send(8'h6B);
    q = s + 2;
    wait_until(q + 18); send(8'hE0); send(8'h75);
    wait_until(q + 32);
    check("colr_beats", beats.size(), 3);
    check("colr_t1", beat_time(1), q + 20);
    check("colr_c1", beat_cmd(1), CMD_ROTATE);
    check("colr_t2", beat_time(2), q + 30);
    check("colr_c2", beat_cmd(2), CMD_LEFT);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h75);

    // ---------------- reset mid-prefix ----------------
    repeat (2) @(negedge clk);
    beats.delete();
    send(8'hE0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_drop", drop_count, 0);
    check("rst_valid", cmd_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h6B);
    repeat (3) @(negedge clk);
    check("rst_no_cmd", beats.size(), 0);
    check("rst_valid_after", cmd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
